// File: rtl/shift_ctrl_if.sv
// Parallel-in handshake and serial-out status bundle for shift_ctrl.
// The requester drives the master side; the serializer is the slave side.
interface shift_ctrl_if #(
  parameter int BIT  = 8,
  parameter int DIVW = 4
);
  localparam int CW = $clog2(BIT) + 1;

  logic            i_valid;
  logic [BIT-1:0]  i_data;
  logic [DIVW-1:0] i_div;
  logic            i_msb_first;
  logic            o_ready;
  logic            o_serial;
  logic            o_load;
  logic            o_busy;
  logic            o_done;
  logic [CW-1:0]   o_bitcnt;

  modport master (
    output i_valid, i_data, i_div, i_msb_first,
    input  o_ready, o_serial, o_load, o_busy, o_done, o_bitcnt
  );

  modport slave (
    input  i_valid, i_data, i_div, i_msb_first,
    output o_ready, o_serial, o_load, o_busy, o_done, o_bitcnt
  );
endinterface

// File: rtl/shift_ctrl.sv
// Parallel-to-serial controller: accepts a word on a valid/ready handshake,
// shifts it out one bit per (div+1) clocks, then spends one GAP cycle
// pulsing o_done before returning to IDLE.
module shift_ctrl #(
  parameter int BIT  = 8,
  parameter int DIVW = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  shift_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(BIT) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(BIT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [BIT-1:0]  shreg_q;
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] div_cnt_q;
  logic            msb_q;
  logic [CW-1:0]   bitcnt_q;

  logic accept;
  logic div_tc;
  logic last_bit;

  // Accept is suppressed during reset so a held request cannot load a frame
  // that reset is about to discard.
  assign accept   = bus.i_valid && (state_q == IDLE) && !i_rst;
  assign div_tc   = (div_cnt_q == div_q);
  assign last_bit = div_tc && (bitcnt_q == LAST_BIT);

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> GAP after the last
  // bit's full period, GAP -> IDLE after exactly one cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = GAP;
      GAP:                   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, count the bit period, shift toward the output
  // end with zero fill, and count completed bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg_q   <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      msb_q     <= 1'b0;
      bitcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q   <= bus.i_data;
            div_q     <= bus.i_div;
            msb_q     <= bus.i_msb_first;
            div_cnt_q <= '0;
            bitcnt_q  <= '0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt_q <= '0;
            bitcnt_q  <= bitcnt_q + CW'(1);
            shreg_q   <= msb_q ? {shreg_q[BIT-2:0], 1'b0}
                               : {1'b0, shreg_q[BIT-1:1]};
          end else begin
            div_cnt_q <= div_cnt_q + DIVW'(1);
          end
        end
        GAP: begin
          // Count is held at BIT for the GAP cycle and cleared on the way
          // back to IDLE.
          bitcnt_q <= '0;
          shreg_q  <= '0;
        end
        default: begin
          bitcnt_q <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state; ready is forced high during the reset cycle.
  always_comb begin
    bus.o_ready  = i_rst || (state_q == IDLE);
    bus.o_load   = accept;
    bus.o_busy   = (state_q == SHIFT) || (state_q == GAP);
    bus.o_done   = (state_q == GAP);
    bus.o_serial = 1'b0;
    if (state_q == SHIFT) bus.o_serial = msb_q ? shreg_q[BIT-1] : shreg_q[0];
    bus.o_bitcnt = bitcnt_q;
  end
endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: each step pushes the expected per-cycle
// output vector into a scoreboard, and every clock pops one and compares.
module tb_shift_ctrl;
  localparam int BIT  = 8;
  localparam int DIVW = 4;

  typedef struct packed {
    logic       ready;
    logic       load;
    logic       busy;
    logic       done;
    logic       serial;
    logic [3:0] bitcnt;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  shift_ctrl_if #(.BIT(BIT), .DIVW(DIVW)) bus ();

  shift_ctrl #(.BIT(BIT), .DIVW(DIVW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string tag      = "init";

  function automatic exp_t mk(input logic ready, load, busy, done, serial,
                              input int bc);
    exp_t e;
    e.ready = ready; e.load = load; e.busy = busy; e.done = done;
    e.serial = serial; e.bitcnt = 4'(bc);
    return e;
  endfunction

  // Expected cycles of a whole frame, starting with its accept cycle.
  task automatic push_frame(input logic [BIT-1:0] data, input int div,
                            input logic msb);
    sb.push_back(mk(1, 1, 0, 0, 0, 0));
    for (int j = 0; j < BIT; j++) begin
      logic b;
      b = msb ? data[BIT-1-j] : data[j];
      for (int k = 0; k <= div; k++) sb.push_back(mk(0, 0, 1, 0, b, j));
    end
    sb.push_back(mk(0, 0, 1, 1, 0, BIT));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(mk(1, 0, 0, 0, 0, 0));
  endtask

  // One clock: compare mid-cycle, then return just after the next edge,
  // where the caller drives new inputs.
  task automatic cycle();
    exp_t obs, exp_v;
    @(negedge i_clk);
    obs = '{bus.o_ready, bus.o_load, bus.o_busy, bus.o_done, bus.o_serial,
            bus.o_bitcnt};
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard_empty observed=%b", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s rdy/ld/bsy/dn/ser/cnt observed=%b expected=%b t=%0t",
               tag, obs, exp_v, $time);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input logic v, input logic [BIT-1:0] d,
                       input logic [DIVW-1:0] dv, input logic m);
    bus.i_valid = v; bus.i_data = d; bus.i_div = dv; bus.i_msb_first = m;
  endtask

  initial begin
    drive(0, '0, '0, 0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    // Second reset cycle: already IDLE, ready forced high.
    tag = "reset";
    push_idle(1);
    drive(1, 8'hAA, 4'd0, 0);          // accept must be suppressed in reset
    sb[0].load = 1'b0;
    cycle();

    // Released, no request for 5 cycles.
    tag = "idle";
    i_rst = 1'b0;
    drive(0, '0, '0, 0);
    push_idle(5);
    run(5);

    // 0x55, one clock per bit, LSB first.
    tag = "lsb_div0";
    drive(1, 8'b0101_0101, 4'd0, 0);
    push_frame(8'b0101_0101, 0, 0);
    run(1);
    drive(0, '0, '0, 0);
    run(9);
    push_idle(1);
    run(1);

    // 0xC3, three clocks per bit, MSB first.
    tag = "msb_div2";
    drive(1, 8'b1100_0011, 4'd2, 1);
    push_frame(8'b1100_0011, 2, 1);
    run(1);
    drive(0, '0, '0, 0);
    run(25);
    push_idle(2);
    run(2);

    // Two queued words with valid held: second accept 10 cycles after first.
    tag = "back2back";
    drive(1, 8'h0F, 4'd0, 0);
    push_frame(8'h0F, 0, 0);
    push_frame(8'hF0, 0, 0);
    run(1);
    drive(1, 8'hF0, 4'd0, 0);
    run(9);
    run(1);
    drive(0, 8'h55, 4'd3, 1);          // mid-frame changes must not matter
    run(9);
    push_idle(1);
    run(1);

    // Reset at bit 3 of 0xFF; a held request is taken right after release.
    tag = "reset_abort";
    drive(1, 8'hFF, 4'd0, 1);
    sb.push_back(mk(1, 1, 0, 0, 0, 0));
    for (int j = 0; j < 3; j++) sb.push_back(mk(0, 0, 1, 0, 1, j));
    run(1);
    drive(1, 8'h81, 4'd0, 1);
    run(3);
    i_rst = 1'b1;
    sb.push_back(mk(1, 0, 1, 0, 1, 3));
    run(1);
    i_rst = 1'b0;
    push_frame(8'h81, 0, 1);
    run(1);
    drive(0, '0, '0, 0);
    run(9);
    push_idle(1);
    run(1);

    // Divider and order changed mid-frame apply to the next frame only.
    tag = "div_latch";
    drive(1, 8'hA5, 4'd0, 0);
    push_frame(8'hA5, 0, 0);
    push_frame(8'h3C, 5, 1);
    run(1);
    drive(1, 8'h3C, 4'd5, 1);
    run(9);
    run(1);
    drive(0, '0, '0, 0);
    run(6 * BIT + 1);
    push_idle(1);
    run(1);

    // Maximum divider: 16 clocks per bit without early wrap.
    tag = "div_max";
    drive(1, 8'h96, 4'hF, 0);
    push_frame(8'h96, 15, 0);
    run(1);
    drive(0, '0, '0, 0);
    run(16 * BIT + 1);
    push_idle(2);
    run(2);

    tag = "sb_drain";
    n_checks++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL %s leftover observed=%0d expected=0", tag, sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
